carry_select_adder4: RTL and testbench



---
 rtl/alu_pkg.sv | 12 +
 rtl/csa_block.sv | 35 +++
 rtl/carry_select_adder4.sv | 108 ++++++++++
 tb/tb_carry_select_adder4.sv | 127 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
//------------------------------------------------------------------------------
// alu_pkg : shared sizing defaults for the ALU adder datapath
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package alu_pkg;
  localparam int ADD_WIDTH = 4;
  localparam int ADD_BLOCK = 2;
endpackage

`default_nettype wire

// File: rtl/csa_block.sv
//------------------------------------------------------------------------------
// csa_block : BLOCK-bit ripple adder slice used by the carry-select adder
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module csa_block #(
  parameter int BLOCK = alu_pkg::ADD_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  // The ripple carry is held in a scalar that walks up the slice, so no
  // vector bit ever depends on another bit of the same vector.
  always_comb begin
    logic c;
    c        = ci;
    s        = '0;
    c_msb_in = ci;
    for (int i = 0; i < BLOCK; i++) begin
      if (i == BLOCK - 1) c_msb_in = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

`default_nettype wire

// File: rtl/carry_select_adder4.sv
//------------------------------------------------------------------------------
// carry_select_adder4 : registered carry-select adder with carry and overflow
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module carry_select_adder4
  import alu_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH,
  parameter int BLOCK = ADD_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NUM_BLK = WIDTH / BLOCK;

  // Index 0 of the *_lo arrays holds the real block-0 result (fed by cin);
  // upper indices hold the carry-in-0 speculation, *_hi the carry-in-1 one.
  logic [BLOCK-1:0] s_lo    [NUM_BLK];
  logic             co_lo   [NUM_BLK];
  logic             cm_lo   [NUM_BLK];
  logic [BLOCK-1:0] s_hi    [NUM_BLK];
  logic             co_hi   [NUM_BLK];
  logic             cm_hi   [NUM_BLK];

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             overflow_d, overflow_q;

  generate
    for (genvar k = 0; k < NUM_BLK; k++) begin : g_blk
      if (k == 0) begin : g_ripple
        csa_block #(.BLOCK(BLOCK)) u_blk (
          .a        (a[BLOCK-1:0]),
          .b        (b[BLOCK-1:0]),
          .ci       (cin),
          .s        (s_lo[0]),
          .co       (co_lo[0]),
          .c_msb_in (cm_lo[0])
        );
        assign s_hi[0]  = s_lo[0];
        assign co_hi[0] = co_lo[0];
        assign cm_hi[0] = cm_lo[0];
      end else begin : g_select
        csa_block #(.BLOCK(BLOCK)) u_blk_c0 (
          .a        (a[k*BLOCK +: BLOCK]),
          .b        (b[k*BLOCK +: BLOCK]),
          .ci       (1'b0),
          .s        (s_lo[k]),
          .co       (co_lo[k]),
          .c_msb_in (cm_lo[k])
        );
        csa_block #(.BLOCK(BLOCK)) u_blk_c1 (
          .a        (a[k*BLOCK +: BLOCK]),
          .b        (b[k*BLOCK +: BLOCK]),
          .ci       (1'b1),
          .s        (s_hi[k]),
          .co       (co_hi[k]),
          .c_msb_in (cm_hi[k])
        );
      end
    end
  endgenerate

  // Block 0 has identical lo/hi copies, so selecting it with cin is a no-op;
  // each later block is chosen by the resolved carry out of its predecessor.
  always_comb begin
    logic carry;
    logic c_msb;
    carry = cin;
    c_msb = 1'b0;
    sum_d = '0;
    for (int k = 0; k < NUM_BLK; k++) begin
      sum_d[k*BLOCK +: BLOCK] = carry ? s_hi[k]  : s_lo[k];
      c_msb                   = carry ? cm_hi[k] : cm_lo[k];
      carry                   = carry ? co_hi[k] : co_lo[k];
    end
    cout_d     = carry;
    overflow_d = c_msb ^ carry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q      <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_carry_select_adder4.sv
//------------------------------------------------------------------------------
// tb_carry_select_adder4 : directed and exhaustive check of carry_select_adder4
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_carry_select_adder4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a   = 4'h0;
  logic [3:0] b   = 4'h0;
  logic       cin = 1'b0;
  logic [3:0] sum;
  logic       cout;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  carry_select_adder4 dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Observed/expected are packed as {overflow, cout, sum}.
  task automatic check(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {overflow, cout, sum};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed {ovf,cout,sum}=%h expected %h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic [3:0] ta, input logic [3:0] tb_, input logic tc, input logic tr);
    @(negedge clk);
    a   = ta;
    b   = tb_;
    cin = tc;
    rst = tr;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] model(input logic [3:0] ma, input logic [3:0] mb, input logic mc);
    logic [4:0] full;
    logic       ovf;
    full = {1'b0, ma} + {1'b0, mb} + {4'b0, mc};
    ovf  = (ma[3] == mb[3]) && (full[3] != ma[3]);
    return {ovf, full};
  endfunction

  initial begin
    step(4'hF, 4'hF, 1'b1, 1'b1);
    check("reset_edge1", 6'h00);
    step(4'hF, 4'hF, 1'b1, 1'b1);
    check("reset_edge2", 6'h00);

    step(4'h4, 4'h3, 1'b0, 1'b0);
    check("4+3", 6'h07);
    step(4'h7, 4'h1, 1'b0, 1'b0);
    check("7+1_ovf", 6'h28);
    step(4'h8, 4'h8, 1'b0, 1'b0);
    check("8+8_cout_ovf", 6'h30);
    step(4'hF, 4'h1, 1'b0, 1'b0);
    check("F+1_wrap", 6'h10);
    step(4'hF, 4'hF, 1'b1, 1'b0);
    check("F+F+1", 6'h1F);
    step(4'h7, 4'h0, 1'b1, 1'b0);
    check("7+0+cin_ovf", 6'h28);

    // New operands applied before the edge must not show until after it.
    @(negedge clk);
    a = 4'h2; b = 4'h2; cin = 1'b0;
    #1;
    check("latency_hold", 6'h28);
    @(posedge clk);
    #1;
    check("latency_update", 6'h04);
    step(4'h9, 4'h9, 1'b0, 1'b0);
    check("b2b_9+9", 6'h32);

    // Reset mid-stream clears on the next edge; data resumes one edge later.
    step(4'h5, 4'h5, 1'b0, 1'b1);
    check("mid_reset", 6'h00);
    step(4'h2, 4'h3, 1'b0, 1'b0);
    check("after_reset", 6'h05);

    // A rst pulse between edges is ignored by the synchronous reset.
    @(negedge clk);
    a = 4'h1; b = 4'h1; cin = 1'b1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("glitch_rst_ignored", 6'h03);

    for (int i = 0; i < 512; i++) begin
      logic [3:0] va;
      logic [3:0] vb;
      logic       vc;
      va = i[8:5];
      vb = i[4:1];
      vc = i[0];
      step(va, vb, vc, 1'b0);
      check($sformatf("sweep_a%h_b%h_c%0d", va, vb, vc), model(va, vb, vc));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
